// File: rtl/npc_unit.sv
// Registered IF-stage program counter: next-PC selection, EPC, misaligned-jr trap
// and a circular return-address stack for jal / jr $ra prediction.
module npc_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [WIDTH-1:0] br_pc,
  input  logic [WIDTH-1:0] boffset,
  input  logic             jump,
  input  logic [WIDTH-1:0] jaddr,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc,
  input  logic             eret,
  input  logic             ras_push,
  input  logic [WIDTH-1:0] ras_push_data,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_plus8,
  output logic [WIDTH-1:0] epc,
  output logic             addr_err,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] epc_nxt;
  logic             err_nxt;
  logic [WIDTH-1:0] br_target;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr;
  logic [PW:0]      ras_cnt;
  logic [PW-1:0]    ras_ptr_m1;

  assign pc_plus4  = pc + WIDTH'(4);
  assign pc_plus8  = pc + WIDTH'(8);
  // The shift drops the top two offset bits; everything wraps modulo 2^WIDTH.
  assign br_target = br_pc + WIDTH'(4) + {boffset[WIDTH-3:0], 2'b00};

  // Next-PC priority: exc > eret > stall > jump > jr (trap if misaligned) > branch > +4.
  always_comb begin
    pc_nxt  = pc_plus4;
    epc_nxt = epc;
    err_nxt = 1'b0;
    if (exc) begin
      pc_nxt  = EXC_VECTOR;
      epc_nxt = pc;
    end else if (eret) begin
      pc_nxt  = epc;
    end else if (stall) begin
      pc_nxt  = pc;
    end else if (jump) begin
      pc_nxt  = jaddr;
    end else if (jr) begin
      if (jr_target[1:0] != 2'b00) begin
        pc_nxt  = EXC_VECTOR;
        epc_nxt = jr_target;
        err_nxt = 1'b1;
      end else begin
        pc_nxt  = jr_target;
      end
    end else if (branch) begin
      pc_nxt  = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      epc      <= '0;
      addr_err <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      epc      <= epc_nxt;
      addr_err <= err_nxt;
    end
  end

  assign ras_ptr_m1 = ras_ptr - PW'(1);
  assign ras_empty  = (ras_cnt == '0);
  assign ras_full   = (ras_cnt == DEPTH_C);
  assign ras_top    = ras_empty ? '0 : ras_mem[ras_ptr_m1];

  // Circular stack: when full, a push overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem[i] <= '0;
    end else if (ras_push && (!ras_pop || ras_empty)) begin
      ras_mem[ras_ptr] <= ras_push_data;
      ras_ptr          <= ras_ptr + PW'(1);
      if (!ras_full) ras_cnt <= ras_cnt + (PW+1)'(1);
    end else if (ras_push && ras_pop) begin
      ras_mem[ras_ptr_m1] <= ras_push_data;
    end else if (ras_pop && !ras_empty) begin
      ras_ptr <= ras_ptr_m1;
      ras_cnt <= ras_cnt - (PW+1)'(1);
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Directed-vector bench for npc_unit: PC priority chain, EPC/trap behaviour and RAS.
module tb_npc_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset, stall, branch, jump, jr, exc, eret, ras_push, ras_pop;
  logic [WIDTH-1:0] br_pc, boffset, jaddr, jr_target, ras_push_data;
  logic [WIDTH-1:0] pc, pc_plus4, pc_plus8, epc, ras_top;
  logic             addr_err, ras_empty, ras_full;

  int n_vec = 0;
  int n_err = 0;

  npc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .br_pc(br_pc),
    .boffset(boffset), .jump(jump), .jaddr(jaddr), .jr(jr), .jr_target(jr_target),
    .exc(exc), .eret(eret), .ras_push(ras_push), .ras_push_data(ras_push_data),
    .ras_pop(ras_pop), .pc(pc), .pc_plus4(pc_plus4), .pc_plus8(pc_plus8),
    .epc(epc), .addr_err(addr_err), .ras_top(ras_top), .ras_empty(ras_empty),
    .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; branch = 0; jump = 0; jr = 0; exc = 0; eret = 0;
    ras_push = 0; ras_pop = 0;
    br_pc = '0; boffset = '0; jaddr = '0; jr_target = '0; ras_push_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic goto(input logic [WIDTH-1:0] a);
    jump = 1; jaddr = a;
    step();
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    ras_push = 1; ras_push_data = d;
    step();
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    // reset state and free run
    check("rst_pc", pc, 32'h3000);
    check("rst_epc", epc, 32'h0);
    check("rst_err", 32'(addr_err), 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    check("rst_full", 32'(ras_full), 32'h0);
    check("rst_top", ras_top, 32'h0);
    step(); check("run1", pc, 32'h3004);
    step(); check("run2", pc, 32'h3008);
    check("plus4", pc_plus4, 32'h300C);
    check("plus8", pc_plus8, 32'h3010);

    // backward branch, then jump beats branch
    branch = 1; br_pc = 32'h3010; boffset = 32'hFFFF_FFFE;
    step(); check("branch", pc, 32'h300C);
    branch = 1; br_pc = 32'h3010; boffset = 32'hFFFF_FFFE; jump = 1; jaddr = 32'h3400;
    step(); check("jmp_over_br", pc, 32'h3400);

    // stall holds, exc overrides stall, eret returns
    goto(32'h3020);
    stall = 1; branch = 1; br_pc = 32'h3020; boffset = 32'h10;
    step(); check("stall1", pc, 32'h3020);
    stall = 1; branch = 1;
    step(); check("stall2", pc, 32'h3020);
    stall = 1; exc = 1;
    step(); check("exc_pc", pc, 32'h4180); check("exc_epc", epc, 32'h3020);
    eret = 1;
    step(); check("eret_pc", pc, 32'h3020); check("eret_epc", epc, 32'h3020);
    step(); check("post_eret", pc, 32'h3024);

    // exc and eret together: exc wins
    exc = 1; eret = 1;
    step(); check("exc_eret_pc", pc, 32'h4180); check("exc_eret_epc", epc, 32'h3024);
    // eret during stall still returns
    stall = 1; eret = 1;
    step(); check("eret_stall", pc, 32'h3024);

    // misaligned jr traps for exactly one cycle, aligned jr jumps
    goto(32'h3040);
    jr = 1; jr_target = 32'h3102;
    step(); check("jr_bad_pc", pc, 32'h4180); check("jr_bad_epc", epc, 32'h3102);
    check("jr_bad_err", 32'(addr_err), 32'h1);
    jr = 1; jr_target = 32'h3100;
    step(); check("jr_ok_pc", pc, 32'h3100); check("jr_ok_err", 32'(addr_err), 32'h0);
    check("jr_ok_epc", epc, 32'h3102);
    // jump outranks jr
    jump = 1; jaddr = 32'h3200; jr = 1; jr_target = 32'h3302;
    step(); check("jmp_over_jr", pc, 32'h3200); check("jmp_jr_err", 32'(addr_err), 32'h0);

    // reset in the middle of a trap and a stall wipes everything
    jr = 1; jr_target = 32'h3001;
    step(); check("trap2_err", 32'(addr_err), 32'h1);
    reset = 1; stall = 1; exc = 1;
    step(); check("mid_rst_pc", pc, 32'h3000); check("mid_rst_epc", epc, 32'h0);
    check("mid_rst_err", 32'(addr_err), 32'h0);

    // RAS overflow wraps, pops drain in LIFO order
    push(32'hA0); push(32'hA4); push(32'hA8);
    check("ras_3_full", 32'(ras_full), 32'h0);
    push(32'hAC);
    check("ras_4_full", 32'(ras_full), 32'h1); check("ras_4_top", ras_top, 32'hAC);
    push(32'hB0);
    check("ras_5_full", 32'(ras_full), 32'h1); check("ras_5_top", ras_top, 32'hB0);
    ras_pop = 1; step(); check("pop1", ras_top, 32'hAC);
    ras_pop = 1; step(); check("pop2", ras_top, 32'hA8);
    ras_pop = 1; step(); check("pop3", ras_top, 32'hA4);
    check("pop3_empty", 32'(ras_empty), 32'h0);
    ras_pop = 1; step(); check("pop4", ras_top, 32'h0);
    check("pop4_empty", 32'(ras_empty), 32'h1);
    ras_pop = 1; step(); check("pop5", ras_top, 32'h0);
    check("pop5_empty", 32'(ras_empty), 32'h1);
    push(32'hD0);
    check("after_pop5", ras_top, 32'hD0);
    ras_pop = 1; step();

    // push+pop replaces top; on empty it is a plain push
    push(32'hA0); push(32'hA4);
    ras_push = 1; ras_pop = 1; ras_push_data = 32'hC0;
    step(); check("pp_top", ras_top, 32'hC0);
    ras_pop = 1; step(); check("pp_below", ras_top, 32'hA0);
    ras_pop = 1; step(); check("pp_drained", 32'(ras_empty), 32'h1);
    ras_push = 1; ras_pop = 1; ras_push_data = 32'hC0;
    step(); check("pp_empty_top", ras_top, 32'hC0);
    check("pp_empty_flag", 32'(ras_empty), 32'h0);
    ras_pop = 1; step(); check("pp_empty_cnt1", 32'(ras_empty), 32'h1);

    // RAS ignores stall
    stall = 1; ras_push = 1; ras_push_data = 32'hE0;
    step(); check("ras_stall", ras_top, 32'hE0);

    // pc wraps to zero
    goto(32'hFFFF_FFFC);
    check("near_wrap_p4", pc_plus4, 32'h0);
    step(); check("wrap", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
- Registered program-counter unit for the pipelined MIPS core, successor to the combinational next-PC logic.
- Holds the IF-stage PC and selects the next PC from the following sources:
  - sequential +4
  - branch
  - jump
  - register jump (jr)
  - exception vector
  - eret return
- Adds pipeline stall hold, an EPC register, misaligned-jr trapping and a parametrised return-address stack (RAS) for jal/jr $ra prediction.
- Sits between the hazard unit/ID-stage decode and the instruction memory address port.

Parameters:
- WIDTH, 32, address width in bits (≥8).
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, exception entry address.
- RAS_DEPTH, 4, RAS entries (power of 2, ≥2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC (and EPC) this cycle.
- branch  in  1  ID-stage branch taken.
- br_pc  in  WIDTH  address of the branch instruction.
- boffset  in  WIDTH  sign-extended 16-bit word offset.
- jump  in  1  j/jal taken.
- jaddr  in  WIDTH  full jump target.
- jr  in  1  jr/jalr taken.
- jr_target  in  WIDTH  register jump target.
- exc  in  1  exception request.
- eret  in  1  return from exception.
- ras_push  in  1  push ras_push_data (jal issued).
- ras_push_data  in  WIDTH  return address to push.
- ras_pop  in  1  pop top entry (jr $ra issued).
- pc  out  WIDTH  current PC register.
- pc_plus4  out  WIDTH  pc+4.
- pc_plus8  out  WIDTH  pc+8.
- epc  out  WIDTH  saved exception PC.
- addr_err  out  1  registered pulse, misaligned jr trapped.
- ras_top  out  WIDTH  top RAS entry, 0 when empty.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - pc=RESET_PC, epc=0, addr_err=0.
  - RAS count=0, pointer=0, entries cleared to 0.
  - ras_empty=1, ras_full=0.
- Next-PC priority, evaluated each edge when not reset:
  1. exc: pc<=EXC_VECTOR, epc<=pc. Applies even when stall=1.
  2. eret: pc<=epc. epc unchanged. Applies even when stall=1.
  3. stall: pc held.
  4. jump: pc<=jaddr.
  5. jr with jr_target[1:0]!=0: pc<=EXC_VECTOR, epc<=jr_target, addr_err<=1 for exactly one cycle.
  6. jr with aligned target: pc<=jr_target.
  7. branch: pc<=br_pc+4+(boffset<<2).
  8. Otherwise: pc<=pc+4.
- Arithmetic is modulo 2^WIDTH:
  - the shift drops the top 2 bits;
  - no overflow flag;
  - pc wraps from all-ones-minus-3 to 0.
- pc_plus4/pc_plus8 are combinational from the pc register; pc is valid from the first edge after reset.
- addr_err is 0 in every cycle except the one after a trapped jr.
- exc and eret asserted together: exc wins; epc<=pc.
- RAS is independent of stall and the PC priority chain; callers gate it.
  - Push only: entry[ptr]<=data, ptr++, count=min(count+1,RAS_DEPTH). When full, the oldest entry is overwritten circularly and count stays RAS_DEPTH.
  - Pop only: ptr--, count-- if count>0. Pop when empty is ignored (no pointer move).
  - Push and pop together: top entry replaced by data, count unchanged. If empty, treated as push only.
  - ras_top = entry[ptr-1] when count>0, else 0. Combinational from registers.
- Reset asserted mid-stall or mid-trap: all state returns to reset values on that edge; no pending effect survives.

Test Plan:
1. Reset, then 3 free-running cycles -> pc 0x3000, 0x3004, 0x3008; pc_plus8=0x3010 while pc=0x3008.
2. branch=1, br_pc=0x3010, boffset=0xFFFF_FFFE -> next pc=0x300C. Same cycle with jump=1, jaddr=0x3400 -> pc=0x3400.
3. stall=1 for 2 cycles at pc=0x3020 with branch=1 -> pc holds 0x3020. exc=1 during stall -> pc=0x4180, epc=0x3020. eret next -> pc=0x3020.
4. jr=1, jr_target=0x3102 at pc=0x3040 -> pc=0x4180, epc=0x3102, addr_err=1 for exactly one cycle. jr_target=0x3100 -> pc=0x3100, addr_err=0.
5. RAS_DEPTH=4: push 0xA0,0xA4,0xA8,0xAC,0xB0 -> ras_full=1, ras_top=0xB0. Pop 4 times -> ras_top 0xAC, 0xA8, 0xA4, then 0 with ras_empty=1. Fifth pop -> no change.
6. Push+pop in the same cycle with top=0xA4 and data=0xC0 -> ras_top=0xC0, count unchanged. Same on empty RAS -> count=1, ras_top=0xC0. pc=0xFFFF_FFFC free-run -> pc=0x0000_0000.
